// File: rtl/priority_index_streamer.sv
// Accepts a request vector and streams the indices of its set bits, highest first,
// one per beat, stopping when the vector is exhausted or MAX_OUT indices have gone out.
module priority_index_streamer #(
  parameter  int WIDTH   = 15,
  parameter  int MAX_OUT = 2,
  localparam int IDXW    = $clog2(WIDTH + 1),
  localparam int CNTW    = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_index,
  output logic [CNTW-1:0]  out_ord,
  output logic             out_last,
  output logic             out_empty
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:1]   r_pending;
  logic [WIDTH:1]   w_pending_next;
  logic [CNTW-1:0]  r_ord;
  logic [CNTW-1:0]  w_ord_next;

  logic [IDXW-1:0]  w_index;
  logic [WIDTH:1]   w_cleared;
  logic             w_empty_vec;
  logic             w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_ord     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_ord     <= w_ord_next;
    end
  end

  // Later (higher) set bits overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    w_index   = '0;
    w_cleared = r_pending;
    for (int i = 1; i <= WIDTH; i++) begin
      if (r_pending[i]) w_index = IDXW'(i);
    end
    for (int i = 1; i <= WIDTH; i++) begin
      if (IDXW'(i) == w_index) w_cleared[i] = 1'b0;
    end
  end

  assign w_empty_vec = (r_pending == '0) && (r_ord == '0);
  assign w_last      = w_empty_vec || (w_cleared == '0) || (r_ord == CNTW'(MAX_OUT - 1));

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_ord_next     = r_ord;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_index      = '0;
    out_ord        = '0;
    out_last       = 1'b0;
    out_empty      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_pending_next = in_req;
          w_ord_next     = '0;
          w_state_next   = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_index = w_index;
        out_ord   = r_ord;
        out_last  = w_last;
        out_empty = w_empty_vec;
        if (out_ready) begin
          w_pending_next = w_cleared;
          w_ord_next     = r_ord + CNTW'(1);
          if (w_last) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_priority_index_streamer.sv
// Directed bench for priority_index_streamer: default 15/2 instance plus a 32/4 instance
// for backpressure, with a first/second reference for the random legacy sweep.
module tb_priority_index_streamer;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:1] a_in_req;
  logic [3:0]  a_out_index;
  logic [1:0]  a_out_ord;
  logic        a_out_last, a_out_empty;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [32:1] b_in_req;
  logic [5:0]  b_out_index;
  logic [2:0]  b_out_ord;
  logic        b_out_last, b_out_empty;

  int n_tests;
  int n_fail;

  priority_index_streamer #(.WIDTH(15), .MAX_OUT(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_req(a_in_req),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_index(a_out_index),
    .out_ord(a_out_ord), .out_last(a_out_last), .out_empty(a_out_empty)
  );

  priority_index_streamer #(.WIDTH(32), .MAX_OUT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_req(b_in_req),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
    .out_ord(b_out_ord), .out_last(b_out_last), .out_empty(b_out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".in_ready"},  64'(a_in_ready),  64'd1);
    chk({tag, ".out_valid"}, 64'(a_out_valid), 64'd0);
    chk({tag, ".out_index"}, 64'(a_out_index), 64'd0);
    chk({tag, ".out_ord"},   64'(a_out_ord),   64'd0);
    chk({tag, ".out_last"},  64'(a_out_last),  64'd0);
    chk({tag, ".out_empty"}, 64'(a_out_empty), 64'd0);
  endtask

  task automatic chk_beat_a(input string tag, input int idx, input int ord,
                            input logic last, input logic empty);
    chk({tag, ".out_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, ".in_ready"},  64'(a_in_ready),  64'd0);
    chk({tag, ".out_index"}, 64'(a_out_index), 64'(idx));
    chk({tag, ".out_ord"},   64'(a_out_ord),   64'(ord));
    chk({tag, ".out_last"},  64'(a_out_last),  64'(last));
    chk({tag, ".out_empty"}, 64'(a_out_empty), 64'(empty));
  endtask

  task automatic chk_beat_b(input string tag, input int idx, input int ord, input logic last);
    chk({tag, ".out_valid"}, 64'(b_out_valid), 64'd1);
    chk({tag, ".out_index"}, 64'(b_out_index), 64'(idx));
    chk({tag, ".out_ord"},   64'(b_out_ord),   64'(ord));
    chk({tag, ".out_last"},  64'(b_out_last),  64'(last));
    chk({tag, ".out_empty"}, 64'(b_out_empty), 64'd0);
  endtask

  // Reference: highest and second-highest set bit, scanning down from the top.
  function automatic void ref_first_second(input logic [15:1] v, output int f, output int s);
    f = 0;
    s = 0;
    for (int i = 15; i >= 1; i--) begin
      if (v[i]) begin
        if (f == 0) f = i;
        else if (s == 0) s = i;
      end
    end
  endfunction

  initial begin
    int exp_b[4];
    logic [15:1] v;
    int f, s;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_req = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_req = '0; b_out_ready = 1'b0;
    tick();
    tick();
    chk_idle_a("reset");
    chk("reset.b_in_ready", 64'(b_in_ready), 64'd1);
    chk("reset.b_out_valid", 64'(b_out_valid), 64'd0);
    rst = 1'b0;
    tick();

    // bits 15,6,3: two winners, bit 3 dropped; in_req changes after accept are ignored
    a_out_ready = 1'b1;
    a_in_req = 15'b100_0000_0010_0100;
    a_in_valid = 1'b1;
    chk("two.accept_ready", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 1'b0;
    a_in_req = 15'h7FFF;
    chk_beat_a("two.b0", 15, 0, 1'b0, 1'b0);
    tick();
    chk_beat_a("two.b1", 6, 1, 1'b1, 1'b0);
    tick();
    chk_idle_a("two.after");

    a_in_req = '0;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk_beat_a("empty.b0", 0, 0, 1'b1, 1'b1);
    tick();
    chk_idle_a("empty.after");

    a_in_req = 15'h0001;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk_beat_a("single.b0", 1, 0, 1'b1, 1'b0);
    tick();
    chk_idle_a("single.after");

    // reset in the middle of a stalled beat
    a_out_ready = 1'b0;
    a_in_req = 15'h7FFF;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk_beat_a("rst.pre", 15, 0, 1'b0, 1'b0);
    tick();
    chk_beat_a("rst.stall", 15, 0, 1'b0, 1'b0);
    rst = 1'b1;
    a_out_ready = 1'b1;
    tick();
    chk_idle_a("rst.c1");
    tick();
    chk_idle_a("rst.c2");
    rst = 1'b0;
    tick();
    chk_idle_a("rst.released");

    // WIDTH=32, MAX_OUT=4: every beat stalled one cycle before acceptance
    exp_b[0] = 32; exp_b[1] = 17; exp_b[2] = 9; exp_b[3] = 1;
    b_out_ready = 1'b0;
    b_in_req = 32'h8001_0101;
    b_in_valid = 1'b1;
    chk("bp.accept_ready", 64'(b_in_ready), 64'd1);
    tick();
    b_in_valid = 1'b0;
    b_in_req = '0;
    for (int k = 0; k < 4; k++) begin
      b_out_ready = 1'b0;
      chk_beat_b($sformatf("bp.b%0d", k), exp_b[k], k, k == 3);
      tick();
      chk_beat_b($sformatf("bp.b%0d_stall", k), exp_b[k], k, k == 3);
      b_out_ready = 1'b1;
      tick();
    end
    chk("bp.after_ready", 64'(b_in_ready), 64'd1);
    chk("bp.after_valid", 64'(b_out_valid), 64'd0);

    // legacy first/second sweep with in_valid held high
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      v = 15'($urandom_range(0, 32767));
      if (n % 4 == 0) v = v & 15'($urandom) & 15'($urandom);
      if (n % 97 == 0) v = '0;
      a_in_req = v;
      chk("rnd.idle_ready", 64'(a_in_ready), 64'd1);
      tick();
      a_in_req = ~v;
      ref_first_second(v, f, s);
      chk_beat_a("rnd.first", f, 0, s == 0, v == '0);
      tick();
      if (s != 0) begin
        chk_beat_a("rnd.second", s, 1, 1'b1, 1'b0);
        tick();
      end
    end
    a_in_valid = 1'b0;
    tick();
    chk_idle_a("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
